// File: rtl/seg_pkg.sv
// Shared segment-pattern constants for the BCD seven-segment decoder.
// Patterns are active-low, common-anode, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_DARK7  = 7'h7F;
    localparam seg_t       SEG_BLANK  = 8'hFF;
    localparam seg_t       SEG_ALL_ON = 8'h00;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational 4-bit digit to 7-segment glyph lookup (active-low).
// Build macro BCD_HEX_EN: defined shows A-F for codes 10-15, undefined darkens them.
module bcd_seg_lut
    import seg_pkg::*;
(
    input  logic [3:0] num,
    output logic [6:0] pattern
);

    // Glyph decode; non-BCD codes depend on the build option
    always_comb begin
        pattern = SEG_DARK7;
        case (num)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
`ifdef BCD_HEX_EN
            4'd10:   pattern = SEG_A;
            4'd11:   pattern = SEG_B;
            4'd12:   pattern = SEG_C;
            4'd13:   pattern = SEG_D;
            4'd14:   pattern = SEG_E;
            4'd15:   pattern = SEG_F;
`endif
            default: pattern = SEG_DARK7;
        endcase
    end

endmodule

// File: rtl/bcd_to_8segment.sv
// Registered BCD-to-seven-segment digit driver with DP, lamp test, blanking and ripple blanking.
// Build macro BCD_HEX_EN selects hex glyphs for codes 10-15 (see bcd_seg_lut).
module bcd_to_8segment
    import seg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       dp,
    input  logic       blank,
    input  logic       lamp_test,
    input  logic       rbi,
    output logic [7:0] seg,
    output logic       rbo
);

    logic [6:0] glyph_s;
    seg_t       seg_next_s;
    logic       rbo_next_s;
    seg_t       seg_r;
    logic       rbo_r;

    bcd_seg_lut u_lut (
        .num     (num),
        .pattern (glyph_s)
    );

    // Override priority: lamp test beats blank beats ripple blank beats normal decode
    always_comb begin
        seg_next_s = SEG_BLANK;
        rbo_next_s = 1'b0;
        if (lamp_test) begin
            seg_next_s = SEG_ALL_ON;
        end else if (blank) begin
            seg_next_s = SEG_BLANK;
        end else if (rbi && (num == 4'd0)) begin
            // A suppressed leading zero also darkens its DP and tells the next digit down
            seg_next_s = SEG_BLANK;
            rbo_next_s = 1'b1;
        end else begin
            seg_next_s = {~dp, glyph_s};
        end
    end

    // Output register with synchronous reset to a dark digit
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r <= SEG_BLANK;
            rbo_r <= 1'b0;
        end else begin
            seg_r <= seg_next_s;
            rbo_r <= rbo_next_s;
        end
    end

    assign seg = seg_r;
    assign rbo = rbo_r;

endmodule

// File: tb/tb_bcd_to_8segment.sv
// Scoreboard bench for bcd_to_8segment: driver pushes model predictions, negedge monitor compares.
// Reference glyphs are built from lists of lit segment letters; honours BCD_HEX_EN.
module tb_bcd_to_8segment;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] num;
    logic       dp;
    logic       blank;
    logic       lamp_test;
    logic       rbi;
    logic [7:0] seg;
    logic       rbo;

    typedef struct packed {
        logic [7:0] seg;
        logic       rbo;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Lit segments per code, by segment letter
`ifdef BCD_HEX_EN
    string lit_tbl[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
`else
    string lit_tbl[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "", "", "", "", "", ""};
`endif

    bcd_to_8segment dut (
        .clock     (clock),
        .reset     (reset),
        .num       (num),
        .dp        (dp),
        .blank     (blank),
        .lamp_test (lamp_test),
        .rbi       (rbi),
        .seg       (seg),
        .rbo       (rbo)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input int n);
        string      s;
        logic [6:0] lit;
        s   = lit_tbl[n];
        lit = 7'd0;
        for (int i = 0; i < s.len(); i++) begin
            lit[int'(s[i]) - 97] = 1'b1;
        end
        return ~lit;
    endfunction

    function automatic exp_t model(input logic r, input logic [3:0] n, input logic d,
                                   input logic bl, input logic lt, input logic ri);
        exp_t e;
        e.rbo = 1'b0;
        if (r)                   e.seg = 8'hFF;
        else if (lt)             e.seg = 8'h00;
        else if (bl)             e.seg = 8'hFF;
        else if (ri && n == 4'd0) begin
            e.seg = 8'hFF;
            e.rbo = 1'b1;
        end else                 e.seg = {~d, glyph(int'(n))};
        return e;
    endfunction

    // Apply one cycle of inputs; the prediction is queued at the edge that captures them
    task automatic step(input logic r, input logic [3:0] n, input logic d,
                        input logic bl, input logic lt, input logic ri);
        reset = r; num = n; dp = d; blank = bl; lamp_test = lt; rbi = ri;
        @(posedge clock);
        sb_q.push_back(model(r, n, d, bl, lt, ri));
        #1;
    endtask

    // Monitor: every registered output after a queued capture is compared
    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (seg !== e.seg || rbo !== e.rbo) begin
                bad++;
                $display("FAIL out: got seg=%h rbo=%b, expected seg=%h rbo=%b at %0t",
                         seg, rbo, e.seg, e.rbo, $time);
            end
        end
    end

    initial begin
        reset = 1'b1; num = 4'd0; dp = 1'b0; blank = 1'b0; lamp_test = 1'b0; rbi = 1'b0;
        #1;
        // Reset held with an 8 and DP requested, then released
        step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        // Digit sweep with DP dark
        for (int i = 0; i < 10; i++) step(1'b0, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        // Ripple blanking and overrides
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // Single-cycle reset in the middle of a sweep
        for (int i = 0; i < 10; i++) step(i == 4, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic with overrides biased to be rare
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
        end
        @(negedge clock);
        @(negedge clock);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
